// File: rtl/timer_core.sv
// timer_core: BCD timekeeping core with NUM_FIELDS two-digit fields, up/down counting,
// lap capture, per-field adjust and internally generated tick/adjust/blink strobes.
module timer_core #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1,
  parameter int ADJ_HZ     = 2,
  parameter int BLINK_HZ   = 1,
  parameter int NUM_FIELDS = 2,
  parameter int FIELD0_MOD = 60,
  parameter int FIELDN_MOD = 100,
  localparam int SEL_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  localparam int W         = 8 * NUM_FIELDS
) (
  input  logic                    MegaClk,
  input  logic                    reset,
  input  logic                    pause,
  input  logic                    dir,
  input  logic                    adj,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    lap_req,
  output logic [W-1:0]            count,
  output logic [W-1:0]            lap,
  output logic                    lap_valid,
  output logic [2*NUM_FIELDS-1:0] blank,
  output logic                    wrap,
  output logic                    expired
);

  logic [W-1:0] count_reg, count_next;
  logic [W-1:0] lap_reg;
  logic         lap_valid_reg;
  logic         wrap_reg, wrap_next;
  logic         expired_reg, expired_next;
  logic         blink_ph_reg;

  // Strobe 0 = tick, 1 = adjust, 2 = blink half-period.
  logic [2:0] strobe;
  logic       tick_stb, adj_stb, blink_stb;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_presc
      localparam int DIV = (gi == 0) ? CLK_HZ / TICK_HZ :
                           (gi == 1) ? CLK_HZ / ADJ_HZ  : CLK_HZ / (2 * BLINK_HZ);
      localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
      localparam logic [CW-1:0] LAST = CW'(DIV - 1);
      logic [CW-1:0] cnt_reg;

      assign strobe[gi] = (cnt_reg == LAST);

      always_ff @(posedge MegaClk) begin
        if (reset)
          cnt_reg <= '0;
        else if (strobe[gi])
          cnt_reg <= '0;
        else
          cnt_reg <= cnt_reg + 1'b1;
      end
    end
  endgenerate

  assign tick_stb  = strobe[0];
  assign adj_stb   = strobe[1];
  assign blink_stb = strobe[2];

  // Per-field wrapped increment/decrement and boundary flags, all from the current count.
  logic [7:0]            inc_f [NUM_FIELDS];
  logic [7:0]            dec_f [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] at_max, at_zero;

  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      localparam int MOD = (gi == 0) ? FIELD0_MOD : FIELDN_MOD;
      localparam logic [3:0] TENS_MAX = 4'(MOD / 10 - 1);
      logic [3:0] ones, tens;

      assign ones        = count_reg[8*gi +: 4];
      assign tens        = count_reg[8*gi+4 +: 4];
      assign at_max[gi]  = (ones == 4'd9) && (tens == TENS_MAX);
      assign at_zero[gi] = (ones == 4'd0) && (tens == 4'd0);
      assign inc_f[gi]   = (ones != 4'd9)     ? {tens, ones + 4'd1} :
                           (tens == TENS_MAX) ? 8'h00 : {tens + 4'd1, 4'd0};
      assign dec_f[gi]   = (ones != 4'd0) ? {tens, ones - 4'd1} :
                           (tens == 4'd0) ? {TENS_MAX, 4'd9} : {tens - 4'd1, 4'd9};
    end
  endgenerate

  // Ripple carry/borrow: a field changes only when every lower field wrapped.
  logic [W-1:0] up_val, dn_val, adj_val;
  logic         carry, borrow;

  always_comb begin
    up_val  = count_reg;
    dn_val  = count_reg;
    adj_val = count_reg;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      if (carry)
        up_val[8*f +: 8] = inc_f[f];
      if (borrow)
        dn_val[8*f +: 8] = dec_f[f];
      if (int'(sel) == f)
        adj_val[8*f +: 8] = inc_f[f];
      carry  = carry & at_max[f];
      borrow = borrow & at_zero[f];
    end
  end

  always_comb begin
    count_next   = count_reg;
    wrap_next    = 1'b0;
    expired_next = expired_reg;
    if (adj) begin
      expired_next = 1'b0;
      if (adj_stb)
        count_next = adj_val;
    end else begin
      if (!dir)
        expired_next = 1'b0;
      if (tick_stb && !pause) begin
        if (!dir) begin
          count_next = up_val;
          wrap_next  = carry;
        end else if (&at_zero) begin
          expired_next = 1'b1;
        end else begin
          count_next = dn_val;
          if (dn_val == '0)
            expired_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge MegaClk) begin
    if (reset) begin
      count_reg     <= '0;
      lap_reg       <= '0;
      lap_valid_reg <= 1'b0;
      wrap_reg      <= 1'b0;
      expired_reg   <= 1'b0;
      blink_ph_reg  <= 1'b0;
    end else begin
      count_reg   <= count_next;
      wrap_reg    <= wrap_next;
      expired_reg <= expired_next;
      if (blink_stb)
        blink_ph_reg <= ~blink_ph_reg;
      if (lap_req) begin
        lap_reg       <= count_reg;
        lap_valid_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    blank = '0;
    for (int f = 0; f < NUM_FIELDS; f++)
      if (adj && !blink_ph_reg && int'(sel) == f)
        blank[2*f +: 2] = 2'b11;
  end

  assign count     = count_reg;
  assign lap       = lap_reg;
  assign lap_valid = lap_valid_reg;
  assign wrap      = wrap_reg;
  assign expired   = expired_reg;

endmodule
